lift_car_model: RTL

- Behavioural-synthesisable plant model of the lift car and shaft: the far end of the controller interface.
- Consumes the controller's direction/motion/door_open commands and produces the one-hot floor_sense the controller reads.
- Models floor-to-floor travel time, door travel time and command-violation faults.
- Drives the controller in closed-loop benches and FPGA demos.

---
 rtl/lift_car_model.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lift_car_model.sv
// lift_car_model: plant model of a lift car and its shaft, standing in for the
// real mechanics on the far side of the controller interface.
// The model consumes the controller's direction, motion and door_open
// commands. It produces the one-hot floor_sense that the controller reads,
// and it flags command violations as sticky faults.
//
// Ports:
//   clk             clock, rising-edge
//   reset           asynchronous, active-low reset
//   direction       1 = up, 0 = down; sampled only at departure
//   motion          movement request
//   door_open       door open request
//   fault_clr       (only with LIFT_CAR_FAULT_CLR_EN) clears both faults
//   floor_sense     one-hot floor while standing, zero while travelling
//   cur_floor       index of the last floor reached
//   arrive          one-cycle pulse on arrival at a floor
//   door_closed     door position is 0
//   door_fully_open door position is DOOR_CYCLES
//   fault_door      sticky door/motion interlock violation
//   fault_limit     sticky request to move beyond the top or bottom floor
//
// Optional feature macro: LIFT_CAR_FAULT_CLR_EN (adds the fault_clr input).
//
// state    | meaning
// AT_FLOOR | car standing at cur_floor; door may move
// TRAVEL   | car between floors; door held closed
module lift_car_model #(
  parameter int N_FLOORS      = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 4,
  parameter int START_FLOOR   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        direction,
  input  logic                        motion,
  input  logic                        door_open,
`ifdef LIFT_CAR_FAULT_CLR_EN
  input  logic                        fault_clr,
`endif
  output logic [N_FLOORS-1:0]         floor_sense,
  output logic [$clog2(N_FLOORS)-1:0] cur_floor,
  output logic                        arrive,
  output logic                        door_closed,
  output logic                        door_fully_open,
  output logic                        fault_door,
  output logic                        fault_limit
);

  localparam int FW = $clog2(N_FLOORS);
  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  localparam logic [FW-1:0]       TOP_FLOOR = FW'(N_FLOORS - 1);
  localparam logic [FW-1:0]       RST_FLOOR = FW'(START_FLOOR);
  localparam logic [TW-1:0]       TRAV_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]       DOOR_MAX  = DW'(DOOR_CYCLES);
  localparam logic [N_FLOORS-1:0] ONE_HOT0  = N_FLOORS'(1);

  typedef enum logic {AT_FLOOR, TRAVEL} state_t;

  state_t        state;
  logic          dir_q;
  logic [TW-1:0] travel_cnt;
  logic [DW-1:0] door_pos;

  logic          in_range;
  logic          depart;
  logic          last_leg;
  logic          viol_door;
  logic          viol_limit;
  logic [DW-1:0] door_nxt;
  logic [FW-1:0] floor_nxt;

  always_comb begin
    in_range   = direction ? (cur_floor < TOP_FLOOR) : (cur_floor != '0);
    depart     = (state == AT_FLOOR) && motion && door_closed && in_range;
    last_leg   = (state == TRAVEL) && (travel_cnt == TRAV_LAST);
    viol_door  = ((state == AT_FLOOR) && motion && !door_closed) ||
                 ((state == TRAVEL) && door_open);
    viol_limit = (state == AT_FLOOR) && motion && !in_range;
    floor_nxt  = dir_q ? cur_floor + 1'b1 : cur_floor - 1'b1;

    // The door only moves while the car stands still; a departing car
    // leaves with the door shut, so the position stays at zero.
    door_nxt = '0;
    if ((state == AT_FLOOR) && !depart) begin
      door_nxt = door_pos;
      if (door_open && (door_pos < DOOR_MAX))
        door_nxt = door_pos + 1'b1;
      else if (!door_open && (door_pos != '0))
        door_nxt = door_pos - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= AT_FLOOR;
      dir_q           <= 1'b0;
      travel_cnt      <= '0;
      door_pos        <= '0;
      cur_floor       <= RST_FLOOR;
      floor_sense     <= ONE_HOT0 << RST_FLOOR;
      arrive          <= 1'b0;
      door_closed     <= 1'b1;
      door_fully_open <= 1'b0;
      fault_door      <= 1'b0;
      fault_limit     <= 1'b0;
    end else begin
      arrive          <= 1'b0;
      door_pos        <= door_nxt;
      door_closed     <= (door_nxt == '0);
      door_fully_open <= (door_nxt == DOOR_MAX);

      // A violation in the clearing cycle keeps the fault set.
`ifdef LIFT_CAR_FAULT_CLR_EN
      fault_door  <= viol_door  | (fault_door  & ~fault_clr);
      fault_limit <= viol_limit | (fault_limit & ~fault_clr);
`else
      fault_door  <= fault_door  | viol_door;
      fault_limit <= fault_limit | viol_limit;
`endif

      case (state)
        AT_FLOOR: begin
          if (depart) begin
            state       <= TRAVEL;
            dir_q       <= direction;
            travel_cnt  <= '0;
            floor_sense <= '0;
          end
        end
        TRAVEL: begin
          if (last_leg) begin
            state       <= AT_FLOOR;
            cur_floor   <= floor_nxt;
            floor_sense <= ONE_HOT0 << floor_nxt;
            arrive      <= 1'b1;
          end else begin
            travel_cnt <= travel_cnt + 1'b1;
          end
        end
        default: state <= AT_FLOOR;
      endcase
    end
  end

endmodule
